bimodal_predictor: RTL and testbench

- Parametrised table of saturating branch-direction counters, indexed by low PC bits.
- Replaces the single combinational 2-bit next-state block with a clocked table: per-entry counter storage, a registered prediction port, an update port with same-index bypass, and a sequenced table-clear operation.
- Sits in the fetch stage. Predictions are requested at fetch; updates arrive from branch resolution in execute.

---
 rtl/bimodal_predictor.sv | 94 +++++++++
 tb/tb_bimodal_predictor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bimodal_predictor.sv
// bimodal_predictor: table of saturating branch-direction counters with registered lookup, update bypass and clear sweep
module bimodal_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int INIT_VAL   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pred_valid,
  input  logic [INDEX_BITS-1:0] pred_index,
  output logic                  pred_out_valid,
  output logic                  pred_taken,
  output logic [CTR_BITS-1:0]   pred_ctr,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  clear,
  output logic                  busy
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] INIT = CTR_BITS'(INIT_VAL);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [INDEX_BITS-1:0] LAST = '1;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t r_state;
  logic [INDEX_BITS-1:0] r_ptr;
  logic r_busy;
  logic [CTR_BITS-1:0] r_table [DEPTH];
  logic r_pred_out_valid;
  logic [CTR_BITS-1:0] r_pred_ctr;
  logic w_upd_en, w_pred_en;
  logic [CTR_BITS-1:0] w_cur, w_next, w_pred;
  // saturating next value for the update entry; same-index prediction sees it directly
  always_comb begin
    w_upd_en = upd_valid && !r_busy;
    w_pred_en = pred_valid && !r_busy;
    w_cur = r_table[upd_index];
    w_next = upd_taken ? ((w_cur == CTR_MAX) ? w_cur : w_cur + CTR_BITS'(1))
                       : ((w_cur == '0) ? w_cur : w_cur - CTR_BITS'(1));
    w_pred = (w_upd_en && upd_index == pred_index) ? w_next : r_table[pred_index];
  end
  // clear sequencer: one entry re-initialised per cycle, busy mirrors the sweep state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_busy <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clear) begin
            r_state <= SWEEP;
            r_busy <= 1'b1;
          end
        end
        SWEEP: begin
          r_ptr <= r_ptr + INDEX_BITS'(1);
          if (r_ptr == LAST) begin
            r_state <= IDLE;
            r_busy <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy <= 1'b0;
        end
      endcase
    end
  end
  // counter storage: sweep writes take the table, updates are dropped meanwhile
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= INIT;
    end else if (r_busy) begin
      r_table[r_ptr] <= INIT;
    end else if (w_upd_en) begin
      r_table[upd_index] <= w_next;
    end
  end
  // registered prediction result; counter value holds between valid results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pred_out_valid <= 1'b0;
      r_pred_ctr <= '0;
    end else begin
      r_pred_out_valid <= w_pred_en;
      if (w_pred_en) r_pred_ctr <= w_pred;
    end
  end
  assign pred_out_valid = r_pred_out_valid;
  assign pred_ctr = r_pred_ctr;
  assign pred_taken = r_pred_ctr[CTR_BITS-1];
  assign busy = r_busy;
endmodule

// File: tb/tb_bimodal_predictor.sv
// tb_bimodal_predictor: directed and randomized checks of two predictor configurations against a table model
module tb_bimodal_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pred_valid = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0, clear = 1'b0;
  logic [5:0] pred_index = '0, upd_index = '0;
  logic pred_out_valid, pred_taken, busy;
  logic [1:0] pred_ctr;
  logic p_pred_valid = 1'b0, p_upd_valid = 1'b0, p_upd_taken = 1'b0, p_clear = 1'b0;
  logic [3:0] p_pred_index = '0, p_upd_index = '0;
  logic p_pred_out_valid, p_pred_taken, p_busy;
  logic [2:0] p_pred_ctr;
  int n_vec = 0;
  int n_err = 0;
  int m1[64];
  int m2[16];
  int sw1, sw2, e1_c, e2_c;
  bit e1_v, e2_v;

  always #5 clk = ~clk;

  bimodal_predictor u_dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_index(pred_index),
    .pred_out_valid(pred_out_valid), .pred_taken(pred_taken), .pred_ctr(pred_ctr),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .clear(clear), .busy(busy)
  );

  bimodal_predictor #(.INDEX_BITS(4), .CTR_BITS(3), .INIT_VAL(3)) u_par (
    .clk(clk), .rst(rst),
    .pred_valid(p_pred_valid), .pred_index(p_pred_index),
    .pred_out_valid(p_pred_out_valid), .pred_taken(p_pred_taken), .pred_ctr(p_pred_ctr),
    .upd_valid(p_upd_valid), .upd_index(p_upd_index), .upd_taken(p_upd_taken),
    .clear(p_clear), .busy(p_busy)
  );

  function automatic int sat(input int v, input bit t, input int mx);
    return t ? (v < mx ? v + 1 : mx) : (v > 0 ? v - 1 : 0);
  endfunction

  task automatic mreset();
    foreach (m1[i]) m1[i] = 1;
    foreach (m2[i]) m2[i] = 3;
    sw1 = 0; sw2 = 0; e1_v = 0; e2_v = 0; e1_c = 0; e2_c = 0;
  endtask

  // one clock of stimulus to both designs; the model answers the request after applying
  // the same-cycle update, and a sweep is modelled as a busy countdown over a cleared table
  task automatic cyc(input bit pv, input int pi, input bit uv, input int ui, input bit ut, input bit cl);
    {pred_valid, upd_valid, upd_taken, clear} = {pv, uv, ut, cl};
    pred_index = 6'(pi); upd_index = 6'(ui);
    {p_pred_valid, p_upd_valid, p_upd_taken, p_clear} = {pv, uv, ut, cl};
    p_pred_index = 4'(pi); p_upd_index = 4'(ui);
    if (sw1 == 0 && uv) m1[ui & 63] = sat(m1[ui & 63], ut, 3);
    e1_v = pv && sw1 == 0;
    if (e1_v) e1_c = m1[pi & 63];
    if (sw1 > 0) sw1--;
    else if (cl) begin sw1 = 64; foreach (m1[i]) m1[i] = 1; end
    if (sw2 == 0 && uv) m2[ui & 15] = sat(m2[ui & 15], ut, 7);
    e2_v = pv && sw2 == 0;
    if (e2_v) e2_c = m2[pi & 15];
    if (sw2 > 0) sw2--;
    else if (cl) begin sw2 = 16; foreach (m2[i]) m2[i] = 3; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mreset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if ({pred_out_valid, pred_taken, pred_ctr, busy} !== 5'b0) begin n_err++; $display("FAIL reset_out: got %b want 00000", {pred_out_valid, pred_taken, pred_ctr, busy}); end
    n_vec++; if ({p_pred_out_valid, p_pred_taken, p_pred_ctr, p_busy} !== 6'b0) begin n_err++; $display("FAIL reset_out_par: got %b want 000000", {p_pred_out_valid, p_pred_taken, p_pred_ctr, p_busy}); end
    rst = 1'b0;
    cyc(1, 5, 0, 0, 0, 0);
    n_vec++; if ({pred_out_valid, pred_ctr, pred_taken} !== 4'b1010) begin n_err++; $display("FAIL first_pred: got v/ctr/t %b want 1/01/0", {pred_out_valid, pred_ctr, pred_taken}); end
    n_vec++; if ({p_pred_out_valid, p_pred_ctr, p_pred_taken} !== 5'b10110) begin n_err++; $display("FAIL first_pred_par: got v/ctr/t %b want 1/011/0", {p_pred_out_valid, p_pred_ctr, p_pred_taken}); end
  endtask

  task automatic test_saturate();
    repeat (3) cyc(0, 0, 1, 3, 1, 0);
    cyc(1, 3, 0, 0, 0, 0);
    n_vec++; if (pred_ctr !== 2'd3 || pred_taken !== 1'b1) begin n_err++; $display("FAIL up3: got ctr %0d t %0d want 3 1", pred_ctr, pred_taken); end
    n_vec++; if (p_pred_ctr !== 3'd6 || p_pred_taken !== 1'b1) begin n_err++; $display("FAIL up3_par: got ctr %0d t %0d want 6 1", p_pred_ctr, p_pred_taken); end
    repeat (2) cyc(0, 0, 1, 3, 1, 0);
    cyc(1, 3, 0, 0, 0, 0);
    n_vec++; if (pred_ctr !== 2'd3) begin n_err++; $display("FAIL sat_high: got %0d want 3", pred_ctr); end
    n_vec++; if (p_pred_ctr !== 3'd7) begin n_err++; $display("FAIL sat_high_par: got %0d want 7", p_pred_ctr); end
    repeat (5) cyc(0, 0, 1, 3, 0, 0);
    cyc(1, 3, 0, 0, 0, 0);
    n_vec++; if (pred_ctr !== 2'd0 || pred_taken !== 1'b0) begin n_err++; $display("FAIL down5: got ctr %0d t %0d want 0 0", pred_ctr, pred_taken); end
    n_vec++; if (p_pred_ctr !== 3'd2) begin n_err++; $display("FAIL down5_par: got %0d want 2", p_pred_ctr); end
    cyc(0, 0, 1, 3, 0, 0);
    cyc(1, 3, 0, 0, 0, 0);
    n_vec++; if (pred_ctr !== 2'd0) begin n_err++; $display("FAIL sat_low: got %0d want 0", pred_ctr); end
    n_vec++; if (p_pred_ctr !== 3'd1) begin n_err++; $display("FAIL down6_par: got %0d want 1", p_pred_ctr); end
  endtask

  task automatic test_bypass();
    cyc(1, 7, 1, 7, 1, 0);
    n_vec++; if ({pred_out_valid, pred_ctr, pred_taken} !== 4'b1101) begin n_err++; $display("FAIL bypass: got v/ctr/t %b want 1/10/1", {pred_out_valid, pred_ctr, pred_taken}); end
    n_vec++; if (p_pred_ctr !== 3'd4 || p_pred_taken !== 1'b1) begin n_err++; $display("FAIL bypass_par: got %0d want 4", p_pred_ctr); end
    cyc(1, 8, 1, 7, 1, 0);
    n_vec++; if (pred_ctr !== 2'd1 || pred_taken !== 1'b0) begin n_err++; $display("FAIL diff_index: got %0d want 1", pred_ctr); end
    n_vec++; if (p_pred_ctr !== 3'd3) begin n_err++; $display("FAIL diff_index_par: got %0d want 3", p_pred_ctr); end
    cyc(1, 7, 1, 7, 1, 0);
    n_vec++; if (pred_ctr !== 2'd3) begin n_err++; $display("FAIL bypass_sat: got %0d want 3", pred_ctr); end
    n_vec++; if (p_pred_ctr !== 3'd6) begin n_err++; $display("FAIL bypass_seq_par: got %0d want 6", p_pred_ctr); end
    cyc(1, 7, 1, 7, 0, 0);
    n_vec++; if (pred_ctr !== 2'd2) begin n_err++; $display("FAIL bypass_dec: got %0d want 2", pred_ctr); end
    n_vec++; if (p_pred_ctr !== 3'd5) begin n_err++; $display("FAIL bypass_dec_par: got %0d want 5", p_pred_ctr); end
  endtask

  task automatic test_clear();
    int ids[3] = '{0, 31, 63};
    int obs;
    for (int j = 0; j < 3; j++) repeat (2) cyc(0, 0, 1, ids[j], 1, 0);
    cyc(1, 63, 0, 0, 0, 1);
    n_vec++; if (pred_ctr !== 2'd3) begin n_err++; $display("FAIL preclear_read: got %0d want 3", pred_ctr); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL clear_start: got busy %0d want 1", busy); end
    obs = (busy === 1'b1) ? 1 : 0;
    for (int k = 0; k < 200 && busy === 1'b1; k++) begin
      cyc(1, int'($urandom_range(0, 63)), 1, ids[k % 3], 1, k == 10);
      n_vec++; if (pred_out_valid !== e1_v) begin n_err++; $display("FAIL sweep_pred_valid: got %0d want %0d", pred_out_valid, e1_v); end
      n_vec++; if (p_busy !== (sw2 > 0)) begin n_err++; $display("FAIL sweep_busy_par: got %0d want %0d", p_busy, sw2 > 0); end
      if (busy === 1'b1) obs++;
    end
    n_vec++; if (obs !== 64) begin n_err++; $display("FAIL clear_len: got %0d cycles want 64", obs); end
    for (int j = 0; j < 3; j++) begin
      cyc(1, ids[j], 0, 0, 0, 0);
      n_vec++; if (pred_out_valid !== 1'b1 || pred_ctr !== 2'd1) begin n_err++; $display("FAIL post_clear[%0d]: got v %0d ctr %0d want 1 1", ids[j], pred_out_valid, pred_ctr); end
      n_vec++; if (p_pred_ctr !== 3'(e2_c)) begin n_err++; $display("FAIL post_clear_par[%0d]: got %0d want %0d", ids[j], p_pred_ctr, e2_c); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    cyc(0, 0, 0, 0, 0, 1);
    repeat (19) cyc(0, 0, 1, 5, 1, 0);
    rst = 1'b1;
    mreset();
    #1;
    n_vec++; if (busy !== 1'b0 || p_busy !== 1'b0) begin n_err++; $display("FAIL rst_abort: got busy %0d/%0d want 0/0", busy, p_busy); end
    n_vec++; if (pred_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0d want 0", pred_out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      cyc(1, i, 0, 0, 0, 0);
      n_vec++; if (pred_out_valid !== 1'b1 || pred_ctr !== 2'd1) begin n_err++; $display("FAIL rst_table[%0d]: got v %0d ctr %0d want 1 1", i, pred_out_valid, pred_ctr); end
      n_vec++; if (p_pred_ctr !== 3'd3) begin n_err++; $display("FAIL rst_table_par[%0d]: got %0d want 3", i, p_pred_ctr); end
    end
    cyc(0, 0, 0, 0, 0, 1);
    n_vec++; if (busy !== 1'b1 || p_busy !== 1'b1) begin n_err++; $display("FAIL clear_after_rst: got busy %0d/%0d want 1/1", busy, p_busy); end
    for (int k = 0; k < 100 && (busy === 1'b1 || p_busy === 1'b1); k++) cyc(0, 0, 0, 0, 0, 0);
    n_vec++; if (busy !== 1'b0 || p_busy !== 1'b0) begin n_err++; $display("FAIL drain: got busy %0d/%0d want 0/0", busy, p_busy); end
  endtask

  task automatic test_param();
    int want;
    int obs;
    for (int k = 0; k < 6; k++) begin
      cyc(1, 9, 1, 9, 1, 0);
      want = (k + 4 > 7) ? 7 : k + 4;
      n_vec++; if (p_pred_ctr !== 3'(want) || p_pred_taken !== (want >= 4)) begin n_err++; $display("FAIL par_up%0d: got ctr %0d t %0d want %0d", k, p_pred_ctr, p_pred_taken, want); end
      n_vec++; if (pred_ctr !== 2'(e1_c)) begin n_err++; $display("FAIL par_up_def%0d: got %0d want %0d", k, pred_ctr, e1_c); end
    end
    for (int k = 0; k < 9; k++) begin
      cyc(1, 9, 1, 9, 0, 0);
      want = (6 - k < 0) ? 0 : 6 - k;
      n_vec++; if (p_pred_ctr !== 3'(want) || p_pred_taken !== (want >= 4)) begin n_err++; $display("FAIL par_dn%0d: got ctr %0d t %0d want %0d", k, p_pred_ctr, p_pred_taken, want); end
    end
    cyc(0, 0, 0, 0, 0, 1);
    obs = (p_busy === 1'b1) ? 1 : 0;
    for (int k = 0; k < 100 && p_busy === 1'b1; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (p_busy === 1'b1) obs++;
    end
    n_vec++; if (obs !== 16) begin n_err++; $display("FAIL par_clear_len: got %0d cycles want 16", obs); end
    for (int k = 0; k < 100 && busy === 1'b1; k++) cyc(0, 0, 0, 0, 0, 0);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL par_drain: got busy %0d want 0", busy); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      int pi = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
      int ui = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
      cyc(bit'($urandom_range(0, 1)), pi, bit'($urandom_range(0, 1)), ui, bit'($urandom_range(0, 1)), $urandom_range(0, 299) == 0);
      n_vec++; if (pred_out_valid !== e1_v) begin n_err++; $display("FAIL rnd_valid@%0d: got %0d want %0d", k, pred_out_valid, e1_v); end
      n_vec++; if (pred_ctr !== 2'(e1_c)) begin n_err++; $display("FAIL rnd_ctr@%0d: got %0d want %0d", k, pred_ctr, e1_c); end
      n_vec++; if (pred_taken !== (e1_c >= 2)) begin n_err++; $display("FAIL rnd_taken@%0d: got %0d want %0d", k, pred_taken, e1_c >= 2); end
      n_vec++; if (busy !== (sw1 > 0)) begin n_err++; $display("FAIL rnd_busy@%0d: got %0d want %0d", k, busy, sw1 > 0); end
      n_vec++; if (p_pred_out_valid !== e2_v) begin n_err++; $display("FAIL rnd_valid_par@%0d: got %0d want %0d", k, p_pred_out_valid, e2_v); end
      n_vec++; if (p_pred_ctr !== 3'(e2_c)) begin n_err++; $display("FAIL rnd_ctr_par@%0d: got %0d want %0d", k, p_pred_ctr, e2_c); end
      n_vec++; if (p_pred_taken !== (e2_c >= 4)) begin n_err++; $display("FAIL rnd_taken_par@%0d: got %0d want %0d", k, p_pred_taken, e2_c >= 4); end
      n_vec++; if (p_busy !== (sw2 > 0)) begin n_err++; $display("FAIL rnd_busy_par@%0d: got %0d want %0d", k, p_busy, sw2 > 0); end
    end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_bypass();
    test_clear();
    test_reset_mid_sweep();
    test_param();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
